// File: rtl/serial_to_parallel_rx_if.sv
// Bundle of serial input, framing, output buffer handshake and status
// signals for the serial-to-parallel receiver.
interface serial_to_parallel_rx_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic          bit_in;
    logic          bit_valid;
    logic          frame_start;
    logic          data_ready;
    logic [WIDTH-1:0] data_out;
    logic          data_valid;
    logic          overflow;
    logic          busy;
    logic [CW-1:0] bit_count;

    // Upstream bit source and downstream word consumer
    modport master (
        output bit_in, bit_valid, frame_start, data_ready,
        input  data_out, data_valid, overflow, busy, bit_count
    );

    // The receiver itself
    modport slave (
        input  bit_in, bit_valid, frame_start, data_ready,
        output data_out, data_valid, overflow, busy, bit_count
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: collects one bit per qualified clock into a
// WIDTH-bit word and hands completed words to a one-deep output buffer with
// a valid/ready handshake. Words arriving while the buffer is full are
// dropped and flagged by a sticky overflow bit.
module serial_to_parallel_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic reset,
    serial_to_parallel_rx_if.slave rx
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] sr_shifted;
    logic [WIDTH-1:0] sr_fresh;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             ovf_reg, ovf_next;
    buf_state_t       state_reg, state_next;

    logic last_bit;
    logic word_done;
    logic take;

    // Shift direction: the fill order decides which end the first bit lands in
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sr_shifted = {rx.bit_in, sr_reg[WIDTH-1:1]};
            assign sr_fresh   = {rx.bit_in, {(WIDTH-1){1'b0}}};
        end else begin : g_msb_first
            assign sr_shifted = {sr_reg[WIDTH-2:0], rx.bit_in};
            assign sr_fresh   = {{(WIDTH-1){1'b0}}, rx.bit_in};
        end
    endgenerate

    // A word completes on the WIDTH-th accepted bit unless framing aborts it
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
    assign word_done = rx.bit_valid && !rx.frame_start && last_bit;
    assign take      = (state_reg == FULL) && rx.data_ready;

    // Bit collection: frame_start realigns, and a coincident bit starts the new word
    always_comb begin
        sr_next  = sr_reg;
        cnt_next = cnt_reg;
        if (rx.frame_start) begin
            if (rx.bit_valid) begin
                sr_next  = sr_fresh;
                cnt_next = CW'(1);
            end else begin
                sr_next  = '0;
                cnt_next = '0;
            end
        end else if (rx.bit_valid) begin
            sr_next  = sr_shifted;
            cnt_next = last_bit ? '0 : cnt_reg + CW'(1);
        end
    end

    // Output buffer FSM: load on completion when empty or draining, else drop
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            EMPTY: begin
                if (word_done) begin
                    data_next  = sr_shifted;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    if (take) begin
                        data_next = sr_shifted;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end else if (take) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Framing clears the sticky flag and takes priority over a new drop
        if (rx.frame_start) begin
            ovf_next = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg    <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= EMPTY;
        end else begin
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            ovf_reg   <= ovf_next;
            state_reg <= state_next;
        end
    end

    assign rx.data_out   = data_reg;
    assign rx.data_valid = (state_reg == FULL);
    assign rx.overflow   = ovf_reg;
    assign rx.busy       = (cnt_reg != '0);
    assign rx.bit_count  = cnt_reg;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: one LSB-first and one MSB-first instance
// share the same stimulus; a bit-array model predicts both and is compared
// on every falling edge, with literal checks at key points.
module tb_serial_to_parallel_rx;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic frame_start = 1'b0;
    logic data_ready = 1'b0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_to_parallel_rx_if #(.WIDTH(WIDTH)) if_l ();
    serial_to_parallel_rx_if #(.WIDTH(WIDTH)) if_m ();

    assign if_l.bit_in      = bit_in;
    assign if_l.bit_valid   = bit_valid;
    assign if_l.frame_start = frame_start;
    assign if_l.data_ready  = data_ready;
    assign if_m.bit_in      = bit_in;
    assign if_m.bit_valid   = bit_valid;
    assign if_m.frame_start = frame_start;
    assign if_m.data_ready  = data_ready;

    serial_to_parallel_rx #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .rx(if_l)
    );
    serial_to_parallel_rx #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .rx(if_m)
    );

    // Model: bits received so far in arrival order, plus buffer contents
    bit   m_bits [WIDTH];
    int   m_cnt = 0;
    logic [WIDTH-1:0] m_out_l = '0;
    logic [WIDTH-1:0] m_out_m = '0;
    logic m_valid = 1'b0;
    logic m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Model update: arrival index of each bit decides its output position
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_out_l <= '0;
            m_out_m <= '0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            automatic bit b [WIDTH];
            automatic int cnt = m_cnt;
            automatic logic done = 1'b0;
            automatic logic take = m_valid && data_ready;
            automatic logic valid_n = m_valid;
            automatic logic ovf_n = m_ovf;
            automatic logic [WIDTH-1:0] wl = '0;
            automatic logic [WIDTH-1:0] wm = '0;
            b = m_bits;
            if (frame_start) cnt = 0;
            if (bit_valid) begin
                b[cnt] = bit_in;
                cnt++;
            end
            if (cnt == WIDTH) begin
                done = 1'b1;
                cnt = 0;
                for (int i = 0; i < WIDTH; i++) begin
                    wl[i] = b[i];
                    wm[WIDTH-1-i] = b[i];
                end
            end
            if (done) begin
                if (!m_valid || take) begin
                    m_out_l <= wl;
                    m_out_m <= wm;
                    valid_n = 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
            end else if (take) begin
                valid_n = 1'b0;
            end
            if (frame_start) ovf_n = 1'b0;
            m_bits  <= b;
            m_cnt   <= cnt;
            m_valid <= valid_n;
            m_ovf   <= ovf_n;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("l_data_out",   if_l.data_out,   m_out_l);
        chk("m_data_out",   if_m.data_out,   m_out_m);
        chk("l_data_valid", if_l.data_valid, m_valid);
        chk("m_data_valid", if_m.data_valid, m_valid);
        chk("l_overflow",   if_l.overflow,   m_ovf);
        chk("m_overflow",   if_m.overflow,   m_ovf);
        chk("l_bit_count",  if_l.bit_count,  m_cnt[CW-1:0]);
        chk("m_bit_count",  if_m.bit_count,  m_cnt[CW-1:0]);
        chk("l_busy",       if_l.busy,       m_cnt != 0);
        chk("m_busy",       if_m.busy,       m_cnt != 0);
    end

    // Drive one qualified bit; returns 2 time units after the accepting edge
    task automatic send_bit(input logic b, input logic fs);
        bit_in = b;
        bit_valid = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
        frame_start = 1'b0;
        $display("bit %0d fs %0d -> l_cnt %0d m_cnt %0d", b, fs, if_l.bit_count, if_m.bit_count);
    endtask

    // Send a byte in arrival order: element 0 of the pattern goes first
    task automatic send_seq(input logic [WIDTH-1:0] pat, input int gap_max);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(pat[i], 1'b0);
            if (gap_max > 0) begin
                automatic int g = $urandom_range(0, gap_max);
                repeat (g) @(posedge clk);
                #2;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b1;
        #11 reset = 1'b0;
        idle(1);
        chk("reset_valid", if_l.data_valid, 1'b0);
        chk("reset_count", if_l.bit_count, 0);

        // LSB-first word 0xC5 with the consumer always ready
        data_ready = 1'b1;
        send_seq(8'hC5, 0);
        @(negedge clk);
        chk("t1_l_data", if_l.data_out, 8'hC5);
        chk("t1_m_data", if_m.data_out, 8'hA3);
        chk("t1_valid",  if_l.data_valid, 1'b1);
        chk("t1_busy",   if_l.busy, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t1_drained", if_l.data_valid, 1'b0);
        $display("t1 data_out l=%h m=%h", if_l.data_out, if_m.data_out);
        idle(1);

        // Arrival order 1,1,0,0,0,1,0,1 with gaps: MSB-first gives 0xC5
        send_seq(8'hA3, 3);
        @(negedge clk);
        chk("t2_m_data", if_m.data_out, 8'hC5);
        chk("t2_l_data", if_l.data_out, 8'hA3);
        idle(3);

        // Backpressure: second word is dropped and overflow sticks
        data_ready = 1'b0;
        send_seq(8'hC5, 0);
        send_seq(8'h3C, 0);
        @(negedge clk);
        chk("t3_held", if_l.data_out, 8'hC5);
        chk("t3_ovf",  if_l.overflow, 1'b1);
        idle(1);
        data_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk("t3_drain_valid", if_l.data_valid, 1'b0);
        chk("t3_ovf_sticky",  if_l.overflow, 1'b1);
        idle(1);
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clear", if_l.overflow, 1'b0);
        idle(1);

        // Simultaneous drain and completion
        data_ready = 1'b0;
        send_seq(8'hC5, 0);
        for (int i = 0; i < WIDTH - 1; i++) send_bit(i == 0, 1'b0);
        data_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        chk("t4_data",  if_l.data_out, 8'h81);
        chk("t4_valid", if_l.data_valid, 1'b1);
        chk("t4_ovf",   if_l.overflow, 1'b0);
        idle(2);

        // Realignment after stray bits
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int i = 1; i < WIDTH; i++) send_bit(i == WIDTH - 1, 1'b0);
        @(negedge clk);
        chk("t5_data", if_l.data_out, 8'h81);
        idle(2);

        // frame_start on what would be the WIDTH-th bit suppresses completion
        for (int i = 0; i < WIDTH - 1; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        chk("t5b_count", if_l.bit_count, 1);
        chk("t5b_valid", if_l.data_valid, 1'b0);
        idle(1);

        // Asynchronous reset mid-word while a word is held
        data_ready = 1'b0;
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        send_seq(8'hC5, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_data",  if_l.data_out, 0);
        chk("t6_rst_valid", if_l.data_valid, 1'b0);
        chk("t6_rst_count", if_l.bit_count, 0);
        chk("t6_rst_busy",  if_l.busy, 1'b0);
        #1 reset = 1'b0;
        idle(1);
        data_ready = 1'b1;
        send_seq(8'h5A, 0);
        @(negedge clk);
        chk("t6_data", if_l.data_out, 8'h5A);
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
